video_timing_ctrl: RTL
======================

Name: video_timing_ctrl

Overview:
- Generates the raster timing that sequences the three per-channel TMDS encoders: data-enable, hsync/vsync and per-channel control codes, plus pixel coordinates for the pixel source.
- Sits between the pixel generator/framebuffer reader and the blue/green/red encoder instances in the HDMI/DVI transmit path.
- Runs on the pixel clock.
- Starts and stops only on frame boundaries.

Parameters:
- H_ACTIVE, 640, active pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, active lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync width (lines)
- V_BP, 33, vertical back porch (lines)
- HS_POL, 0, hsync asserted level (0 = active-low)
- VS_POL, 0, vsync asserted level (0 = active-low)
- CW, 12, coordinate/counter width; must hold H_TOTAL-1 and V_TOTAL-1

Ports:
- clk  in  1  pixel clock
- rst  in  1  reset
- en  in  1  run request; sampled every cycle
- de  out  1  data enable to all three encoders
- hsync  out  1  horizontal sync, polarity applied
- vsync  out  1  vertical sync, polarity applied
- ctl_b  out  2  blue-channel control = {vsync, hsync}
- ctl_g  out  2  green-channel control, constant 2'b00
- ctl_r  out  2  red-channel control, constant 2'b00
- x  out  CW  horizontal position, aligned with de
- y  out  CW  vertical position, aligned with de
- line_start  out  1  one-cycle pulse at x==0 of every line while running
- frame_start  out  1  one-cycle pulse at x==0,y==0
- busy  out  1  high while a frame is in progress

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Constants: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP.
- Line order (h_cnt): active 0..H_ACTIVE-1, then front porch, then sync, then back porch.
- Frame order (v_cnt): same ordering, in lines.
- Top FSM states: IDLE, RUN, DRAIN.
  - IDLE: counters held at 0. On the first edge with en=1, go to RUN with h_cnt=0, v_cnt=0.
  - RUN: h_cnt increments every cycle and wraps H_TOTAL-1 -> 0. On each wrap, v_cnt increments and wraps V_TOTAL-1 -> 0.
  - RUN -> DRAIN: on any cycle with en=0.
  - DRAIN: counting continues. At the wrap (h_cnt=H_TOTAL-1, v_cnt=V_TOTAL-1), go to IDLE if en=0, or continue to RUN if en=1. en re-asserted mid-frame cancels the drain with no discontinuity.
- Outputs are registered decodes of the counters, giving 1-cycle latency. All outputs are mutually aligned.
  - de = RUN|DRAIN && h_cnt<H_ACTIVE && v_cnt<V_ACTIVE.
  - hsync asserted when H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC.
  - vsync asserted when V_ACTIVE+V_FP <= v_cnt < V_ACTIVE+V_FP+V_SYNC, for whole lines. It changes only coincident with line_start.
  - x = h_cnt and y = v_cnt. They keep counting through blanking and are meaningful to consumers only when de=1.
- Reset values, and values held in IDLE:
  - de=0, x=0, y=0, line_start=0, frame_start=0, busy=0.
  - hsync=~HS_POL, vsync=~VS_POL.
  - ctl_b={~VS_POL,~HS_POL}, ctl_g=ctl_r=0.
- busy = registered (state != IDLE). Aligned with the other outputs, so busy rises with the first frame_start and falls one cycle after the final back-porch pixel.
- Reset asserted mid-frame: the next cycle shows reset values. No partial-line completion.
- en toggling within a single frame has no visible effect other than the DRAIN/RUN decision made at the frame wrap.
- Counter arithmetic is unsigned CW bits. No overflow is possible under the stated CW constraint.

Test Plan:
All scenarios use small parameters: H_ACTIVE=8, H_FP=2, H_SYNC=3, H_BP=2 (H_TOTAL=15); V_ACTIVE=4, V_FP=1, V_SYNC=2, V_BP=1 (V_TOTAL=8); HS_POL=VS_POL=0.
- Reset/idle: rst high 3 cycles, then en=0 for 20 cycles -> de=0, hsync=1, vsync=1, ctl_b=2'b11, busy=0, x=y=0 throughout.
- Start latency: en rises, first sampled at edge N -> at edge N+2: frame_start=1, line_start=1, de=1, x=0, y=0, busy=1.
- Line timing, first line after start:
  - de high 8 cycles (x=0..7), low 7 cycles.
  - hsync=0 exactly for x=10,11,12.
  - next line_start 15 cycles after the previous one.
- Frame timing:
  - de=1 only on y=0..3.
  - vsync=0 for lines y=5,6, i.e. 30 cycles, starting on the line_start of y=5.
  - frame_start period = 120 cycles.
- Graceful stop: drop en at y=1, x=3 -> frame completes through y=7, x=14; no further frame_start; busy falls one cycle after x=14, y=7; idle levels held afterward.
- Mid-frame reset: assert rst for one cycle at y=2, x=5 -> next cycle shows reset values. With en held high, frame_start occurs 2 cycles after rst deasserts.

Source files
------------

// File: rtl/video_timing_ctrl.sv
// Raster timing generator for the TMDS transmit path: counts pixels/lines and
// emits registered de, syncs, control codes and coordinates.
`timescale 1ns/1ps
module video_timing_ctrl #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33,
    parameter bit          HS_POL   = 1'b0,
    parameter bit          VS_POL   = 1'b0,
    parameter int unsigned CW       = 12
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    output logic          de,
    output logic          hsync,
    output logic          vsync,
    output logic [1:0]    ctl_b,
    output logic [1:0]    ctl_g,
    output logic [1:0]    ctl_r,
    output logic [CW-1:0] x,
    output logic [CW-1:0] y,
    output logic          line_start,
    output logic          frame_start,
    output logic          busy
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] H_ACT    = CW'(H_ACTIVE);
    localparam logic [CW-1:0] V_ACT    = CW'(V_ACTIVE);
    localparam logic [CW-1:0] HS_START = CW'(H_ACTIVE + H_FP);
    localparam logic [CW-1:0] HS_END   = CW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CW-1:0] VS_START = CW'(V_ACTIVE + V_FP);
    localparam logic [CW-1:0] VS_END   = CW'(V_ACTIVE + V_FP + V_SYNC);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] h_cnt, v_cnt, h_nxt, v_nxt;
    logic          h_wrap, frame_wrap, running;

    assign h_wrap     = (h_cnt == H_LAST);
    assign frame_wrap = h_wrap && (v_cnt == V_LAST);
    assign running    = (state != IDLE);

    // The stop/continue decision is taken only at the frame wrap, so DRAIN
    // and RUN count identically and en can flip freely mid-frame.
    always_comb begin
        state_nxt = state;
        h_nxt     = h_cnt;
        v_nxt     = v_cnt;
        case (state)
            IDLE: begin
                h_nxt = '0;
                v_nxt = '0;
                if (en) state_nxt = RUN;
            end
            RUN, DRAIN: begin
                h_nxt = h_wrap ? '0 : h_cnt + 1'b1;
                if (h_wrap) v_nxt = (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
                if (frame_wrap) state_nxt = en ? RUN : IDLE;
                else            state_nxt = en ? RUN : DRAIN;
            end
            default: begin
                state_nxt = IDLE;
                h_nxt     = '0;
                v_nxt     = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            h_cnt <= '0;
            v_cnt <= '0;
        end else begin
            state <= state_nxt;
            h_cnt <= h_nxt;
            v_cnt <= v_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            de          <= 1'b0;
            hsync       <= ~HS_POL;
            vsync       <= ~VS_POL;
            x           <= '0;
            y           <= '0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            busy        <= 1'b0;
        end else begin
            busy        <= running;
            de          <= running && (h_cnt < H_ACT) && (v_cnt < V_ACT);
            hsync       <= (running && h_cnt >= HS_START && h_cnt < HS_END) ? HS_POL : ~HS_POL;
            vsync       <= (running && v_cnt >= VS_START && v_cnt < VS_END) ? VS_POL : ~VS_POL;
            x           <= h_cnt;
            y           <= v_cnt;
            line_start  <= running && (h_cnt == '0);
            frame_start <= running && (h_cnt == '0) && (v_cnt == '0);
        end
    end

    assign ctl_b = {vsync, hsync};
    assign ctl_g = 2'b00;
    assign ctl_r = 2'b00;

endmodule
